// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, pixel bit positions and controller state
// type for the double-buffered 32x16 bicolour LED framebuffer.
package matrix_pkg;

    localparam int COL_BITS  = 5;
    localparam int ROW_BITS  = 4;
    localparam int COLS      = 1 << COL_BITS;
    localparam int ROWS      = 1 << ROW_BITS;

    // Bit positions inside a 2-bit pixel
    localparam int PIX_RED   = 0;
    localparam int PIX_GREEN = 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        WAIT_SWAP
    } state_t;

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one framebuffer bank, a simple dual-port RAM with a single
// write port and a registered (1-cycle latency) read port. Storage is
// not reset.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled on the clock edge
//   o_rdata  : read data for the address sampled on the previous edge
module fb_bank
    import matrix_pkg::*;
#(
    parameter int ADDR_BITS = ROW_BITS + COL_BITS,
    parameter int DATA_BITS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0] o_rdata
);

    logic [DATA_BITS-1:0] r_mem [1 << ADDR_BITS];
    logic [DATA_BITS-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/matrix_framebuf.sv
// matrix_framebuf: double-buffered bicolour framebuffer feeding the LED
// matrix scan driver. The host writes/clears the back bank; the driver
// reads the front bank. A commit swaps banks only at frame_start.
//   clk, rst_n          : clock, async active-low reset
//   wr_valid/wr_ready   : pixel write handshake (row, col, pix)
//   clear_req           : zero the whole back bank (busy while running)
//   commit              : request swap at the next frame_start
//   frame_start         : frame boundary pulse from the scan driver
//   rd_row/rd_col       : scan read address
//   rd_red/rd_green     : front-bank pixel, 1 cycle after the address
//   swap_pending        : commit accepted, waiting for frame_start
//   swap_done           : one-cycle pulse after the bank swap
//   busy                : clear in progress
module matrix_framebuf
    import matrix_pkg::*;
#(
    parameter int COL_BITS = matrix_pkg::COL_BITS,
    parameter int ROW_BITS = matrix_pkg::ROW_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [COL_BITS-1:0] wr_col,
    input  logic [ROW_BITS-1:0] wr_row,
    input  logic [1:0]          wr_pix,
    input  logic                clear_req,
    input  logic                commit,
    input  logic                frame_start,
    input  logic [ROW_BITS-1:0] rd_row,
    input  logic [COL_BITS-1:0] rd_col,
    output logic                rd_red,
    output logic                rd_green,
    output logic                swap_pending,
    output logic                swap_done,
    output logic                busy
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;

    state_t                r_state;
    logic                  r_front;
    logic                  r_front_d;
    logic                  r_rd_vld;
    logic                  r_swap_done;
    logic [ADDR_BITS-1:0]  r_clr_addr;

    logic                  w_bank_we;
    logic [ADDR_BITS-1:0]  w_bank_waddr;
    logic [1:0]            w_bank_wdata;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [1:0]            w_rd0;
    logic [1:0]            w_rd1;
    logic [1:0]            w_rd_pix;

    // Writes (host or clear) always target the back bank
    assign w_bank_we    = (r_state == CLEAR) || (wr_valid && r_state == IDLE);
    assign w_bank_waddr = (r_state == CLEAR) ? r_clr_addr : {wr_row, wr_col};
    assign w_bank_wdata = (r_state == CLEAR) ? 2'b00 : wr_pix;
    assign w_rd_addr    = {rd_row, rd_col};

    fb_bank #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (2)
    ) u_bank0 (
        .i_clk   (clk),
        .i_we    (w_bank_we && r_front),
        .i_waddr (w_bank_waddr),
        .i_wdata (w_bank_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd0)
    );

    fb_bank #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (2)
    ) u_bank1 (
        .i_clk   (clk),
        .i_we    (w_bank_we && !r_front),
        .i_waddr (w_bank_waddr),
        .i_wdata (w_bank_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd1)
    );

    // Read mux uses the front value that was current when the address was
    // sampled, so a read in the swap cycle still returns old-front data.
    // r_rd_vld holds the outputs low until the RAMs have produced a read.
    assign w_rd_pix     = r_front_d ? w_rd1 : w_rd0;
    assign rd_red       = r_rd_vld & w_rd_pix[PIX_RED];
    assign rd_green     = r_rd_vld & w_rd_pix[PIX_GREEN];

    assign wr_ready     = (r_state == IDLE);
    assign busy         = (r_state == CLEAR);
    assign swap_pending = (r_state == WAIT_SWAP);
    assign swap_done    = r_swap_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_front     <= 1'b0;
            r_front_d   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_swap_done <= 1'b0;
            r_clr_addr  <= '0;
        end else begin
            r_front_d   <= r_front;
            r_rd_vld    <= 1'b1;
            r_swap_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state    <= CLEAR;
                        r_clr_addr <= '0;
                    end else if (commit) begin
                        if (frame_start) begin
                            r_front     <= ~r_front;
                            r_swap_done <= 1'b1;
                        end else begin
                            r_state <= WAIT_SWAP;
                        end
                    end
                end
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == '1) begin
                        r_state <= IDLE;
                    end
                end
                WAIT_SWAP: begin
                    if (frame_start) begin
                        r_front     <= ~r_front;
                        r_swap_done <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
